alu_wb_seq: RTL and testbench

Writeback sequencer directly downstream of the `alu` block; it consumes `aluRslt`, `aluRsltR15` and `ovExcep` for each executed instruction. It serializes results onto the register file's single write port. Multiply and divide results take two consecutive writes: Rd, then R15. Overflow suppresses writeback and latches an exception with the faulting PC. It stalls the upstream pipeline while a second write or an exception is pending.

---
 rtl/alu_wb_seq.sv | 127 ++++++++++++
 tb/tb_alu_wb_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_seq.sv
// rtl/alu_wb_seq.sv - writeback sequencer between the ALU and the register file write port
//
// Serializes ALU results onto the single register file write port. Multiply and
// divide results (wb_kind 10/11) take two writes, Rd then R15, when MULDIV_WB_EN
// is defined; otherwise they are written to Rd only. An overflow on an accepted
// result suppresses the write and latches an exception with the faulting PC.
//
// Optional feature macro: MULDIV_WB_EN
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready  EX-stage handshake; stall = ~in_ready
//   aluRslt            [15:0] low word, [31:16] product high word
//   aluRsltR15         divide remainder
//   ovExcep            overflow flag for this result
//   rd, wb_kind, pc_in destination, writeback kind, PC of the instruction
//   regWrite/wrAddr/wrData  registered register file write port
//   excep, epc         overflow exception pending and faulting PC
//   excep_clr          exception acknowledge from the handler
module alu_wb_seq #(
  parameter int                DATA_W   = 16,
  parameter int                REG_AW   = 4,
  parameter logic [REG_AW-1:0] R15_ADDR = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       aluRslt,
  input  logic [15:0]       aluRsltR15,
  input  logic              ovExcep,
  input  logic [REG_AW-1:0] rd,
  input  logic [1:0]        wb_kind,
  input  logic [15:0]       pc_in,
  output logic              regWrite,
  output logic [REG_AW-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic              excep,
  output logic [15:0]       epc,
  input  logic              excep_clr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_R15 = 2'd1,
    EXCEP  = 2'd2
  } state_t;

  state_t              state_q;
  logic                reg_write_q;
  logic [REG_AW-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                excep_q;
  logic [15:0]         epc_q;
  logic [DATA_W-1:0]   held_q;      // upper word waiting for the R15 write
  logic                accept;

  // Ready drops combinationally with rst so nothing is accepted during reset.
  assign in_ready = (state_q == IDLE) & ~rst;
  assign accept   = in_valid & in_ready;

`ifndef MULDIV_WB_EN
  // High word and remainder only matter for the dual-write sequence.
  logic unused_hi;
  assign unused_hi = ^{aluRsltR15, aluRslt[31:16]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      reg_write_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      excep_q     <= 1'b0;
      epc_q       <= '0;
      held_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          reg_write_q <= 1'b0;
          if (accept) begin
            if (ovExcep) begin
              epc_q   <= pc_in;
              excep_q <= 1'b1;
              state_q <= EXCEP;
            end else if (wb_kind != 2'b00) begin
              reg_write_q <= 1'b1;
              wr_addr_q   <= rd;
              wr_data_q   <= aluRslt[15:0];
`ifdef MULDIV_WB_EN
              if (wb_kind[1]) begin
                // 10: product high word, 11: remainder
                held_q  <= wb_kind[0] ? aluRsltR15 : aluRslt[31:16];
                state_q <= WR_R15;
              end
`endif
            end
          end
        end
        WR_R15: begin
          reg_write_q <= 1'b1;
          wr_addr_q   <= R15_ADDR;
          wr_data_q   <= held_q;
          state_q     <= IDLE;
        end
        EXCEP: begin
          reg_write_q <= 1'b0;
          if (excep_clr) begin
            excep_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          reg_write_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign regWrite = reg_write_q;
  assign wrAddr   = wr_addr_q;
  assign wrData   = wr_data_q;
  assign excep    = excep_q;
  assign epc      = epc_q;

endmodule

// File: tb/tb_alu_wb_seq.sv
// tb/tb_alu_wb_seq.sv - scoreboard testbench for alu_wb_seq
module tb_alu_wb_seq;

`ifdef MULDIV_WB_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] aluRslt;
  logic [15:0] aluRsltR15;
  logic        ovExcep;
  logic [3:0]  rd;
  logic [1:0]  wb_kind;
  logic [15:0] pc_in;
  logic        regWrite;
  logic [3:0]  wrAddr;
  logic [15:0] wrData;
  logic        excep;
  logic [15:0] epc;
  logic        excep_clr;

  alu_wb_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .aluRslt    (aluRslt),
    .aluRsltR15 (aluRsltR15),
    .ovExcep    (ovExcep),
    .rd         (rd),
    .wb_kind    (wb_kind),
    .pc_in      (pc_in),
    .regWrite   (regWrite),
    .wrAddr     (wrAddr),
    .wrData     (wrData),
    .excep      (excep),
    .epc        (epc),
    .excep_clr  (excep_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t expq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: list of register writes an accepted result must cause.
  function automatic void model(input logic [1:0] kind, input logic [3:0] d,
                                input logic [31:0] r, input logic [15:0] r15,
                                input logic ov);
    wr_t w;
    if (ov || kind == 2'b00) return;
    w.addr = d; w.data = r[15:0];
    expq.push_back(w);
    if (MD && kind[1]) begin
      w.addr = 4'hF;
      w.data = kind[0] ? r15 : r[31:16];
      expq.push_back(w);
    end
  endfunction

  // Monitor: every presented write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && regWrite) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", wrAddr, wrData);
      end else begin
        wr_t w;
        w = expq.pop_front();
        chk("wr_addr", {28'd0, wrAddr}, {28'd0, w.addr});
        chk("wr_data", {16'd0, wrData}, {16'd0, w.data});
      end
    end
  end

  // Called just after a falling edge; returns at the falling edge after acceptance
  // with in_valid still high.
  task automatic send(input logic [1:0] kind, input logic [3:0] d, input logic [31:0] r,
                      input logic [15:0] r15, input logic ov, input logic [15:0] pc);
    int n = 0;
    in_valid = 1'b1; wb_kind = kind; rd = d; aluRslt = r;
    aluRsltR15 = r15; ovExcep = ov; pc_in = pc;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
    end else begin
      model(kind, d, r, r15, ov);
    end
    @(negedge clk);
  endtask

  task automatic clear_excep(input int hold);
    for (int i = 0; i < hold; i++) begin
      chk("excep_stall", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    excep_clr = 1'b1;
    @(negedge clk);
    excep_clr = 1'b0;
    chk("excep_cleared", {31'd0, excep}, 32'd0);
    chk("ready_after_clr", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; aluRslt = '0; aluRsltR15 = '0; ovExcep = 1'b0;
    rd = '0; wb_kind = '0; pc_in = '0; excep_clr = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
    chk("rst_wrAddr",   {28'd0, wrAddr}, 32'd0);
    chk("rst_wrData",   {16'd0, wrData}, 32'd0);
    chk("rst_excep",    {31'd0, excep}, 32'd0);
    chk("rst_epc",      {16'd0, epc}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single write, 1-cycle latency, then idle.
    send(2'b01, 4'd3, 32'h0000_0FFF, 16'h0, 1'b0, 16'h0);
    in_valid = 1'b0;
    chk("single_regWrite", {31'd0, regWrite}, 32'd1);
    chk("single_data", {16'd0, wrData}, 32'h0FFF);
    @(negedge clk);
    chk("single_done", {31'd0, regWrite}, 32'd0);

    // Multiply with in_valid held: ready drops only while the R15 write is pending.
    send(2'b10, 4'd2, 32'h00E1_0F00, 16'h0, 1'b0, 16'h0);
    chk("mul_rd_ready", {31'd0, in_ready}, {31'd0, !MD});
    in_valid = 1'b0;
    @(negedge clk);
    chk("mul_r15_ready", {31'd0, in_ready}, 32'd1);
    chk("mul_r15_write", {31'd0, regWrite}, {31'd0, MD});

    // Divide: remainder goes to R15.
    send(2'b11, 4'd4, 32'h0000_000F, 16'h0003, 1'b0, 16'h0);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);

    // Overflow: no write, exception latched for 5 cycles, then cleared.
    send(2'b01, 4'd5, 32'h0000_1234, 16'h0, 1'b1, 16'h0040);
    in_valid = 1'b0;
    chk("ov_no_write", {31'd0, regWrite}, 32'd0);
    chk("ov_excep", {31'd0, excep}, 32'd1);
    chk("ov_epc", {16'd0, epc}, 32'h0040);
    clear_excep(5);
    chk("epc_held", {16'd0, epc}, 32'h0040);

    // Reset during the R15 cycle drops the pending write.
    send(2'b10, 4'd7, 32'hBEEF_1111, 16'h0, 1'b0, 16'h0);
    in_valid = 1'b0;
    #2;
    chk("rst_pending", expq.size(), {31'd0, MD});
    rst = 1'b1;
    #1;
    chk("rst_clears_write", {31'd0, regWrite}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);

    // Back-to-back kind 10.
    for (int i = 0; i < 4; i++) begin
      send(2'b10, 4'(i + 8), {16'hA000 + 16'(i), 16'h5000 + 16'(i)}, 16'h0, 1'b0, 16'h0);
      chk("b2b_ready", {31'd0, in_ready}, {31'd0, !MD});
    end
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      logic [1:0]  k;
      logic        ov;
      logic [15:0] pc;
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        excep_clr = 1'($urandom);
        @(negedge clk);
      end
      excep_clr = 1'b0;
      k  = 2'($urandom);
      ov = ($urandom_range(0, 11) == 0);
      pc = 16'($urandom);
      send(k, 4'($urandom), $urandom, 16'($urandom), ov, pc);
      if (ov) begin
        in_valid = 1'b0;
        chk("rnd_excep", {31'd0, excep}, 32'd1);
        chk("rnd_epc", {16'd0, epc}, {16'd0, pc});
        clear_excep($urandom_range(0, 3));
      end
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("queue_drained", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
